// File: rtl/fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
//
// Round-robin write-side arbiter that multiplexes N_REQ producers onto the
// single push port of the parity FIFO. One producer owns the port at a time
// for a tenure of at most MAX_BURST words; its words pass through a one-entry
// output register that feeds the FIFO's data_i/valid_i/grant_o handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req_data_i   packed requester words, requester k in slice k
//   req_valid_i  requester k has a word
//   req_grant_o  requester k's word is accepted this cycle (one-hot or zero)
//   data_o       word to FIFO data_i
//   valid_o      to FIFO valid_i
//   grant_i      from FIFO grant_o, FIFO accepts data_o this cycle
//   owner_o      current tenure owner, 0 when idle
//   busy_o       high while a tenure is active
//   drop_o       one-cycle pulse after a discarded word
//
// Build option:
//   FIFO_RR_ARBITER_PARITY_FILTER_EN  accepted words whose XOR reduction
//   differs from EVEN_ODD are granted and counted but never forwarded.
//   Without it every accepted word is forwarded and drop_o is tied low.
// ---------------------------------------------------------------------------
module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 4,
    parameter int EVEN_ODD   = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_REQ*(DATA_WIDTH+1)-1:0]     req_data_i,
    input  logic [N_REQ-1:0]                    req_valid_i,
    output logic [N_REQ-1:0]                    req_grant_o,
    output logic [DATA_WIDTH:0]                 data_o,
    output logic                                valid_o,
    input  logic                                grant_i,
    output logic [$clog2(N_REQ)-1:0]            owner_o,
    output logic                                busy_o,
    output logic                                drop_o
);

    localparam int W     = DATA_WIDTH + 1;
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_REQ - 1);

`ifdef FIFO_RR_ARBITER_PARITY_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [W-1:0]       words [N_REQ];
    logic [W-1:0]       owner_word;
    logic               owner_valid;
    logic               rdy;
    logic               accept;
    logic               parity_ok;
    logic               word_ok;
    logic               tenure_end;
    logic [PTR_W-1:0]   owner_inc;

    logic               found;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;
    int unsigned        idx;

    // Unpack the requester bus into per-requester words.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign words[g] = req_data_i[g*W +: W];
    end

    always_comb begin
        owner_word  = words[owner_q];
        owner_valid = req_valid_i[owner_q];
        rdy         = !valid_o || grant_i;
        accept      = (state_q == BURST) && rdy && owner_valid;
        parity_ok   = ((^owner_word) == 1'(EVEN_ODD));
        word_ok     = !FILTER_EN || parity_ok;
        owner_inc   = (owner_q == IDX_LAST) ? '0 : owner_q + PTR_W'(1);
    end

    // The grant is offered whenever the owner could be accepted; it does
    // not wait for the owner's valid, so the handshake stays a plain AND.
    always_comb begin
        req_grant_o = '0;
        if ((state_q == BURST) && rdy) begin
            req_grant_o[owner_q] = 1'b1;
        end
    end

    // Rotating priority search starting at ptr_q, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PTR_W'(idx);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        tenure_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        tenure_end = 1'b1;
                    end
                end else if (!owner_valid) begin
                    tenure_end = 1'b1;
                end
                if (tenure_end) begin
                    state_d = IDLE;
                    ptr_d   = owner_inc;
                    owner_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-entry output register; data_o keeps its last value after the
    // FIFO drains it so only valid_o carries meaning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (accept && word_ok) begin
            data_o  <= owner_word;
            valid_o <= 1'b1;
        end else if (grant_i) begin
            valid_o <= 1'b0;
        end
    end

`ifdef FIFO_RR_ARBITER_PARITY_FILTER_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_o <= 1'b0;
        end else begin
            drop_o <= accept && !word_ok;
        end
    end
`else
    always_comb begin
        drop_o = 1'b0;
    end
`endif

    always_comb begin
        owner_o = owner_q;
        busy_o  = (state_q == BURST);
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int EO = 0;
    localparam int W  = DW + 1;

`ifdef FIFO_RR_ARBITER_PARITY_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_grant_o;
    logic [W-1:0]   data_o;
    logic           valid_o;
    logic           grant_i;
    logic [1:0]     owner_o;
    logic           busy_o;
    logic           drop_o;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .MAX_BURST  (MB),
        .EVEN_ODD   (EO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_grant_o (req_grant_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .grant_i     (grant_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o),
        .drop_o      (drop_o)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus: each requester presents the head of its queue.
    logic [W-1:0] rq [N][$];
    int           acc_cnt [N];

    // Reference model state.
    bit           m_known = 1'b0;
    bit           m_busy;
    int           m_owner;
    int           m_ptr;
    int           m_cnt;
    bit           m_vo;
    logic [W-1:0] m_do;
    bit           m_drop;
    logic [W-1:0] sb [$];

    // Tenure observation.
    bit prev_busy = 1'b0;
    int cur_words = 0;
    int gap       = 0;
    int ten_own [$];
    int ten_words [$];
    int gaps [$];
    int drops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit word_ok(input logic [W-1:0] w);
        return !FILT || ((^w) == 1'(EO));
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0) begin
                req_valid_i[k]        = 1'b1;
                req_data_i[k*W +: W]  = rq[k][0];
            end else begin
                req_valid_i[k]        = 1'b0;
                req_data_i[k*W +: W]  = W'({$urandom, $urandom});
            end
        end
    endtask

    task automatic track_reset();
        ten_own.delete();
        ten_words.delete();
        gaps.delete();
        gap       = 0;
        cur_words = 0;
        prev_busy = busy_o;
    endtask

    task automatic end_tenure();
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % N;
        m_owner = 0;
        m_cnt   = 0;
    endtask

    // Advance the reference model across the coming rising edge.
    task automatic model_step();
        bit           acc;
        bit           found;
        logic [W-1:0] w;
        if (!rst_n) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_vo    = 1'b0;
            m_do    = '0;
            m_drop  = 1'b0;
            sb.delete();
        end else if (m_known) begin
            if (m_vo && grant_i) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else check("fifo_word", data_o, sb.pop_front());
            end
            acc = m_busy && (!m_vo || grant_i) && (rq[m_owner].size() > 0);
            w   = acc ? rq[m_owner][0] : '0;
            if (acc && word_ok(w)) begin
                m_do = w;
                m_vo = 1'b1;
                sb.push_back(w);
            end else if (grant_i) begin
                m_vo = 1'b0;
            end
            m_drop = acc && !word_ok(w);
            if (!m_busy) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!found && rq[(m_ptr + i) % N].size() > 0) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_owner = (m_ptr + i) % N;
                        m_cnt   = 0;
                    end
                end
            end else if (acc) begin
                m_cnt++;
                if (m_cnt == MB) end_tenure();
            end else if (rq[m_owner].size() == 0) begin
                end_tenure();
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] g, v, exp_g;
        drive_inputs();
        @(negedge clk);
        g = req_grant_o;
        v = req_valid_i;
        if (m_known) begin
            exp_g = (m_busy && (!m_vo || grant_i)) ? (4'b0001 << m_owner) : '0;
            check("req_grant_o", req_grant_o, exp_g);
            check("valid_o", valid_o, m_vo);
            check("data_o", data_o, m_do);
            check("owner_o", owner_o, m_owner);
            check("busy_o", busy_o, m_busy);
            check("drop_o", drop_o, m_drop);
        end
        if (busy_o && !prev_busy) begin
            if (ten_own.size() > 0) gaps.push_back(gap);
            ten_own.push_back(int'(owner_o));
            cur_words = 0;
        end
        if (!busy_o && prev_busy) ten_words.push_back(cur_words);
        if (!busy_o) gap++;
        else gap = 0;
        prev_busy = busy_o;
        if (drop_o === 1'b1) drops++;
        model_step();
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (g[k] && v[k]) begin
                    void'(rq[k].pop_front());
                    acc_cnt[k]++;
                    cur_words++;
                end
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        bit idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            cycle();
            n++;
            idle = all_empty() && (valid_o === 1'b0) && (busy_o === 1'b0);
        end
        check("drain", idle, 1);
        cycle();
    endtask

    initial begin
        int           n;
        logic [W-1:0] held;

        rst_n       = 1'b0;
        grant_i     = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        for (int k = 0; k < N; k++) begin
            acc_cnt[k] = 0;
            rq[k].push_back(W'(32'h100 + k));
        end

        // Reset held two cycles with every requester valid.
        for (int r = 0; r < 2; r++) begin
            cycle();
            check("rst_grant", req_grant_o, 0);
            check("rst_valid", valid_o, 0);
            check("rst_data", data_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_owner", owner_o, 0);
        end
        rst_n = 1'b1;
        cycle();
        check("first_busy", busy_o, 1);
        check("first_owner", owner_o, 0);
        check("first_grant", req_grant_o, 4'b0001);
        run_until_idle(100);

        // Single requester, three back-to-back words.
        acc_cnt[1] = 0;
        rq[1].push_back(W'(32'h10));
        rq[1].push_back(W'(32'h12));
        rq[1].push_back(W'(32'h14));
        cycle();
        check("single_busy", busy_o, 1);
        check("single_owner", owner_o, 1);
        cycle();
        check("single_v0", valid_o, 1);
        check("single_d0", data_o, 33'h10);
        cycle();
        check("single_d1", data_o, 33'h12);
        cycle();
        check("single_d2", data_o, 33'h14);
        run_until_idle(50);
        check("single_count", acc_cnt[1], 3);

        // All requesters continuously valid: eight full tenures from ptr=2.
        track_reset();
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 8; j++) rq[k].push_back(W'(32'h1000 + k*16 + j));
        end
        run_until_idle(200);
        check("fair_tenures", ten_own.size(), 8);
        for (int i = 0; i < ten_own.size(); i++) check("fair_owner", ten_own[i], (2 + i) % N);
        for (int i = 0; i < ten_words.size(); i++) check("fair_words", ten_words[i], MB);
        check("fair_gaps", gaps.size(), 7);
        for (int i = 0; i < gaps.size(); i++) check("fair_gap_len", gaps[i], 1);

        // Backpressure inside requester 2's burst.
        track_reset();
        for (int j = 0; j < 4; j++) rq[2].push_back(W'(32'h200 + j));
        n = 0;
        do begin
            cycle();
            n++;
        end while (valid_o !== 1'b1 && n < 20);
        check("bp_wait", valid_o, 1);
        held = data_o;
        check("bp_first", held, 33'h200);
        grant_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            check("bp_valid", valid_o, 1);
            check("bp_grant", req_grant_o, 0);
            check("bp_owner", owner_o, 2);
            check("bp_data", data_o, held);
        end
        grant_i = 1'b1;
        run_until_idle(50);
        check("bp_tenures", ten_own.size(), 1);
        if (ten_words.size() > 0) check("bp_words", ten_words[0], MB);

        // Reset in the middle of requester 3's burst.
        acc_cnt[3] = 0;
        for (int j = 0; j < 4; j++) rq[3].push_back(W'(32'h300 + j));
        n = 0;
        do begin
            cycle();
            n++;
        end while (acc_cnt[3] != 2 && n < 20);
        check("mr_wait", acc_cnt[3], 2);
        rst_n = 1'b0;
        rq[0].push_back(W'(32'h400));
        rq[0].push_back(W'(32'h401));
        cycle();
        rst_n = 1'b1;
        check("mr_valid", valid_o, 0);
        check("mr_busy", busy_o, 0);
        cycle();
        check("mr_busy2", busy_o, 1);
        check("mr_owner", owner_o, 0);
        run_until_idle(100);

`ifdef FIFO_RR_ARBITER_PARITY_FILTER_EN
        // Odd-parity word is swallowed, even-parity word is forwarded.
        drops = 0;
        rq[0].push_back(W'(32'h1));
        rq[0].push_back(W'(32'h6));
        run_until_idle(50);
        check("par_drops", drops, 1);
        check("par_last", data_o, 33'h6);
`endif

        // Randomised traffic, backpressure and occasional reset.
        for (int c = 0; c < 1500; c++) begin
            int k;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, N - 1);
                if (rq[k].size() < 6) rq[k].push_back(W'({$urandom, $urandom}));
            end
            grant_i = ($urandom_range(0, 9) < 7);
            rst_n   = ($urandom_range(0, 249) != 0);
            cycle();
        end
        rst_n   = 1'b1;
        grant_i = 1'b1;
        run_until_idle(400);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin write-side arbiter that lets N_REQ producers share the single push port of the parity FIFO top.
- Each producer presents a valid/grant handshake.
- The arbiter grants one producer at a time for a bounded burst and forwards its words through a one-entry output register to the FIFO's data_i/valid_i/grant_o port.
- It sits directly upstream of the FIFO top and is the only driver of its push interface.

Parameters:
- DATA_WIDTH, 32: payload width; all data ports are DATA_WIDTH+1 bits (bit DATA_WIDTH included, parity-carrying word as used by the FIFO).
- N_REQ, 4: number of requesters, ≥2.
- MAX_BURST, 4: maximum words accepted per tenure, ≥1.
- EVEN_ODD, 0: parity sense for the optional filter; 0 = XOR of all word bits must be 0, 1 = must be 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_data_i  in  N_REQ*(DATA_WIDTH+1)  packed requester words; requester k occupies slice k.
- req_valid_i  in  N_REQ  requester k has a word.
- req_grant_o  out  N_REQ  requester k's word is accepted this cycle.
- data_o  out  DATA_WIDTH+1  word to FIFO data_i.
- valid_o  out  1  to FIFO valid_i.
- grant_i  in  1  from FIFO grant_o; FIFO accepts data_o this cycle.
- owner_o  out  $clog2(N_REQ)  current tenure owner index; 0 when idle.
- busy_o  out  1  high in BURST.
- drop_o  out  1  one-cycle pulse when a word is discarded (optional feature only).

Behaviour:
- Transfer rule: a transfer occurs at a posedge where valid and grant are both high, on either side of the arbiter.
- Reset (rst_n=0 sampled at posedge) puts every element in its reset value:
  - state=IDLE, ptr=0, cnt=0, owner_o=0, busy_o=0;
  - valid_o=0, data_o=0, req_grant_o=0, drop_o=0.
  - Reset mid-burst discards any held word with no handshake to the FIFO.
- Output register ready: rdy = !valid_o || grant_i.
- req_grant_o[k] = (state==BURST) && (owner==k) && rdy. All other bits are 0. At most one bit is high.
- On a requester accept, data_o <= slice owner and valid_o <= 1.
- If grant_i is high and there is no new accept, valid_o <= 0. data_o holds its last value.
- While valid_o=1 and grant_i=0, data_o and valid_o are held stable.
- IDLE state:
  - Search from ptr upward with wrap for the first k where req_valid_i[k]=1.
  - If found: owner<=k, cnt<=0, next state BURST.
  - No grant is issued in the IDLE cycle (one arbitration bubble).
- BURST state:
  - Each accept increments cnt.
  - Go to IDLE with ptr <= (owner+1) mod N_REQ when either:
    - an accept occurs with cnt==MAX_BURST-1; or
    - req_valid_i[owner]=0 at a posedge (voluntary release).
  - A stalled FIFO (rdy=0) does not end the tenure and does not change cnt.
- ptr wraps N_REQ-1 → 0.
- MAX_BURST=1 yields strict one-word round-robin.
- Latency from an idle arbiter with an empty register:
  - req_valid_i asserted before posedge t → IDLE decision at t;
  - req_grant_o high during cycle t+1;
  - valid_o high from t+2.
- Throughput inside a tenure is one word per cycle while grant_i=1.
- owner_o and busy_o are registered and track state.
- Payload bits are not modified. Width of data_o equals one slice exactly.

Optional Feature:
- Macro: FIFO_RR_ARBITER_PARITY_FILTER_EN.
- Defined: an accepted word whose XOR reduction ≠ EVEN_ODD is still granted and counted toward cnt. It is not loaded into the output register: valid_o follows the no-new-accept rule, and drop_o pulses 1 in the cycle after the accept.
- Undefined: every accepted word is forwarded unchanged; drop_o is tied 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid_i=4'b1111 → req_grant_o=0, valid_o=0, data_o=0, busy_o=0 throughout; first grant after release goes to requester 0.
- Single requester: requester 1 presents 0x10, 0x12, 0x14 back-to-back, grant_i=1 → req_grant_o=4'b0010 for 3 cycles; data_o=0x10, 0x12, 0x14 on consecutive cycles, first 2 cycles after request; valid drop → IDLE, ptr=2.
- Fairness: all 4 requesters continuously valid, MAX_BURST=4, grant_i=1 → owner_o sequence 0,1,2,3,0; 4 words each; exactly one idle cycle between tenures.
- Backpressure: during requester 2's burst, grant_i=0 for 5 cycles with valid_o=1 → data_o stable, req_grant_o=0, cnt unchanged; owner_o stays 2; flow resumes on grant_i=1.
- Mid-burst reset: after 2 words from requester 3, rst_n=0 for 1 cycle → next cycle valid_o=0, busy_o=0; with requesters 0 and 3 valid, requester 0 is granted first.
- Parity filter (macro defined, EVEN_ODD=0): requester 0 sends 0x1 then 0x6 → 0x1 granted, drop_o=1 one cycle, never on data_o; 0x6 appears on data_o with valid_o=1.
